// File: rtl/wom_write_buffer.sv
// Posts AHB writes into a small FIFO that drains into a shared single-port RAM when the core is not reading.
// Core reads win the port and are forwarded from pending entries (1-cycle latency); wr_ready drops when the FIFO is full.
module wom_write_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 10,
   parameter int DW    = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          wr_en,
   output logic          wr_ready,
   output logic          wr_ovf,
   input  logic          core_re,
   input  logic [AW-1:0] core_addr,
   output logic [DW-1:0] core_rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   input  logic [DW-1:0] ram_rdata
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0] ent_addr_q [DEPTH];
   logic [DW-1:0] ent_data_q [DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          fwd_hit_q, fwd_hit_d;
   logic [DW-1:0] fwd_data_q, fwd_data_d;

   logic          push;
   logic          pop;
   logic [PW-1:0] idx;

   assign wr_ready = (count_q != FULL);
   assign push     = wr_en && wr_ready;
   assign pop      = !core_re && (count_q != '0);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (pop) begin
         head_d = head_q + 1'b1;
      end
      if (push) begin
         tail_d = tail_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
      if (wr_en && !wr_ready) begin
         ovf_d = 1'b1;
      end
   end

   // Walk from head towards tail so the newest matching entry overrides older ones.
   always_comb begin
      fwd_hit_d  = 1'b0;
      fwd_data_d = '0;
      idx        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if (core_re && (CW'(i) < count_q) && (ent_addr_q[idx] == core_addr)) begin
            fwd_hit_d  = 1'b1;
            fwd_data_d = ent_data_q[idx];
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         fwd_hit_q  <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         fwd_hit_q  <= fwd_hit_d;
         fwd_data_q <= fwd_data_d;
      end
   end

   // Entry storage is left uncleared by reset; count=0 already marks it empty.
   always_ff @(posedge CLK) begin
      if (push) begin
         ent_addr_q[tail_q] <= wr_addr;
         ent_data_q[tail_q] <= wr_data;
      end
   end

   assign ram_we     = pop;
   assign ram_addr   = core_re ? core_addr : ent_addr_q[head_q];
   assign ram_wdata  = ent_data_q[head_q];
   assign wr_ovf     = ovf_q;
   assign core_rdata = fwd_hit_q ? fwd_data_q : ram_rdata;

endmodule

// File: tb/tb_wom_write_buffer.sv
// Directed and randomized checks of wom_write_buffer against a behavioural RAM and reference memory.
module tb_wom_write_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = 10;
   localparam int DW    = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_en = 1'b0;
   logic          wr_ready;
   logic          wr_ovf;
   logic          core_re = 1'b0;
   logic [AW-1:0] core_addr = '0;
   logic [DW-1:0] core_rdata;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_rdata;

   logic [DW-1:0] ram     [1024];
   logic [DW-1:0] ref_mem [1024];
   logic          init_done = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   wom_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .CLK(CLK), .RST(RST),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .wr_ready(wr_ready), .wr_ovf(wr_ovf),
      .core_re(core_re), .core_addr(core_addr), .core_rdata(core_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_rdata(ram_rdata)
   );

   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] init_val(input int a);
      return 16'hC000 | DW'(a);
   endfunction

   // Synchronous single-port RAM, read-first, 1-cycle read latency.
   always @(posedge CLK) begin
      if (!init_done) begin
         for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
         init_done <= 1'b1;
      end else begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         ram_rdata <= ram[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra);
      @(negedge CLK);
      wr_en     = we;
      wr_addr   = wa;
      wr_data   = wd;
      core_re   = re;
      core_addr = ra;
      #1;
   endtask

   initial begin
      int mcount, n_acc;
      logic rd_pend, re, we, acc, pp;
      logic [AW-1:0] a, ra;
      logic [DW-1:0] d, exp_rd;

      // Reset state
      repeat (3) @(negedge CLK);
      #1;
      chk("rst_ready", 32'(wr_ready), 32'd1);
      chk("rst_ovf", 32'(wr_ovf), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_count", 32'(dut.count_q), 32'd0);
      chk("rst_rdata", 32'(core_rdata), 32'(ram_rdata));
      @(negedge CLK);
      RST = 1'b0;

      // Single write, core idle
      drive(1'b1, 10'h005, 16'hA5A5, 1'b0, 10'h000);
      chk("t1_ready", 32'(wr_ready), 32'd1);
      chk("t1_we_pre", 32'(ram_we), 32'd0);
      drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
      chk("t1_we", 32'(ram_we), 32'd1);
      chk("t1_addr", 32'(ram_addr), 32'h005);
      chk("t1_wdata", 32'(ram_wdata), 32'hA5A5);
      chk("t1_ready2", 32'(wr_ready), 32'd1);
      drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
      chk("t1_count", 32'(dut.count_q), 32'd0);
      chk("t1_we_post", 32'(ram_we), 32'd0);
      chk("t1_ram", 32'(ram[5]), 32'hA5A5);

      // Fill under continuous reads, overflow, then drain in order
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 10'h010 + AW'(i), 16'h1000 + DW'(i), 1'b1, 10'h3FF);
         chk("t2_ready_pre", 32'(wr_ready), 32'd1);
         chk("t2_we_blocked", 32'(ram_we), 32'd0);
      end
      drive(1'b1, 10'h014, 16'hDEAD, 1'b1, 10'h3FF);
      chk("t2_full", 32'(wr_ready), 32'd0);
      drive(1'b0, 10'h000, 16'h0000, 1'b1, 10'h3FF);
      chk("t2_ovf", 32'(wr_ovf), 32'd1);
      chk("t2_count", 32'(dut.count_q), 32'd4);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
         chk("t2_we", 32'(ram_we), 32'd1);
         chk("t2_addr", 32'(ram_addr), 32'h010 + 32'(i));
         chk("t2_wdata", 32'(ram_wdata), 32'h1000 + 32'(i));
         chk("t2_ready", 32'(wr_ready), (i == 0) ? 32'd0 : 32'd1);
      end
      drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
      chk("t2_idle", 32'(ram_we), 32'd0);
      chk("t2_ram13", 32'(ram[10'h013]), 32'h1003);
      chk("t2_dropped", 32'(ram[10'h014]), 32'(init_val(10'h014)));

      // Forwarding picks the newest of two entries for the same address
      drive(1'b1, 10'h020, 16'h1111, 1'b1, 10'h3FF);
      drive(1'b1, 10'h020, 16'h2222, 1'b1, 10'h3FF);
      drive(1'b0, 10'h000, 16'h0000, 1'b1, 10'h020);
      drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
      chk("t3_fwd", 32'(core_rdata), 32'h2222);
      chk("t3_ram_old", 32'(ram[10'h020]), 32'(init_val(10'h020)));
      drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
      drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
      chk("t3_ram_new", 32'(ram[10'h020]), 32'h2222);
      chk("t3_count", 32'(dut.count_q), 32'd0);

      // Same-cycle push and read is not forwarded
      drive(1'b1, 10'h030, 16'hBEEF, 1'b1, 10'h030);
      drive(1'b0, 10'h000, 16'h0000, 1'b1, 10'h030);
      chk("t4_same_cycle", 32'(core_rdata), 32'(init_val(10'h030)));
      drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
      chk("t4_next_cycle", 32'(core_rdata), 32'hBEEF);
      drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
      chk("t4_ram", 32'(ram[10'h030]), 32'hBEEF);

      // Simultaneous push and pop at count=2
      drive(1'b1, 10'h040, 16'h4040, 1'b1, 10'h3FF);
      drive(1'b1, 10'h041, 16'h4141, 1'b1, 10'h3FF);
      drive(1'b1, 10'h042, 16'h4242, 1'b0, 10'h000);
      chk("t5_count_pre", 32'(dut.count_q), 32'd2);
      chk("t5_we", 32'(ram_we), 32'd1);
      chk("t5_addr0", 32'(ram_addr), 32'h040);
      drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
      chk("t5_count_post", 32'(dut.count_q), 32'd2);
      chk("t5_addr1", 32'(ram_addr), 32'h041);
      drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
      drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
      chk("t5_drained", 32'(dut.count_q), 32'd0);
      chk("t5_ram42", 32'(ram[10'h042]), 32'h4242);

      // Random traffic against a reference memory; 11 writes accepted so far
      for (int i = 0; i < 1024; i++) ref_mem[i] = ram[i];
      mcount  = 0;
      n_acc   = 0;
      rd_pend = 1'b0;
      exp_rd  = '0;
      for (int c = 0; c < 1000; c++) begin
         re = 1'($urandom_range(0, 1));
         we = ($urandom_range(0, 9) < 6);
         a  = AW'($urandom_range(0, 15));
         d  = DW'($urandom);
         ra = AW'($urandom_range(0, 15));
         drive(we, a, d, re, ra);
         if (rd_pend) chk("rnd_rd", 32'(core_rdata), 32'(exp_rd));
         chk("rnd_ready", 32'(wr_ready), 32'(mcount != DEPTH));
         if (re) exp_rd = ref_mem[ra];
         rd_pend = re;
         acc = we && (mcount != DEPTH);
         pp  = !re && (mcount != 0);
         if (acc) begin
            ref_mem[a] = d;
            n_acc++;
         end
         mcount = mcount + int'(acc) - int'(pp);
      end
      drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
      if (rd_pend) chk("rnd_rd_last", 32'(core_rdata), 32'(exp_rd));
      repeat (DEPTH) drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
      chk("rnd_count", 32'(dut.count_q), 32'd0);
      chk("rnd_tail", 32'(dut.tail_q), 32'((11 + n_acc) % DEPTH));
      chk("rnd_head", 32'(dut.head_q), 32'((11 + n_acc) % DEPTH));
      for (int i = 0; i < 16; i++) chk("rnd_mem", 32'(ram[i]), 32'(ref_mem[i]));

      // Asynchronous reset with three pending writes
      drive(1'b1, 10'h050, 16'h5050, 1'b1, 10'h3FF);
      drive(1'b1, 10'h051, 16'h5151, 1'b1, 10'h3FF);
      drive(1'b1, 10'h052, 16'h5252, 1'b1, 10'h3FF);
      drive(1'b0, 10'h000, 16'h0000, 1'b1, 10'h3FF);
      chk("t6_count", 32'(dut.count_q), 32'd3);
      @(negedge CLK);
      core_re = 1'b0;
      RST     = 1'b1;
      #1;
      chk("t6_we", 32'(ram_we), 32'd0);
      chk("t6_ready", 32'(wr_ready), 32'd1);
      chk("t6_ovf", 32'(wr_ovf), 32'd0);
      chk("t6_rdata", 32'(core_rdata), 32'(ram_rdata));
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 10'h000, 16'h0000, 1'b0, 10'h000);
         chk("t6_no_we", 32'(ram_we), 32'd0);
      end
      for (int i = 0; i < 3; i++)
         chk("t6_ram_kept", 32'(ram[10'h050 + AW'(i)]), 32'(init_val(10'h050 + i)));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/wom_write_buffer.md
# wom_write_buffer

Write-posting buffer between the AHB write-only memory adapter (registered `addr`/`data`/`we` stream) and the single-port 1K×16 block RAM that the engine core also reads. AHB writes are queued in a small FIFO and drained into the RAM only in cycles where the core is not reading. Core reads always win the RAM port, and read data is forwarded from pending FIFO entries so the core never sees stale data. `wr_ready` back-pressures the AHB side (HREADYOUT) when the FIFO is full.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `AW`, 10, word address width
- `DW`, 16, data width

- `CLK`  in  1  single clock, all state on rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `wr_addr`  in  AW  write address from adapter
- `wr_data`  in  DW  write data from adapter
- `wr_en`  in  1  write request, one word per cycle
- `wr_ready`  out  1  FIFO can accept a write this cycle
- `wr_ovf`  out  1  sticky: write arrived while `wr_ready`=0
- `core_re`  in  1  core read request
- `core_addr`  in  AW  core read address
- `core_rdata`  out  DW  read data, valid the cycle after `core_re`
- `ram_addr`  out  AW  RAM address
- `ram_wdata`  out  DW  RAM write data
- `ram_we`  out  1  RAM write enable
- `ram_rdata`  in  DW  RAM read data, synchronous, 1-cycle latency

## Operation
- FIFO: entries {addr, data}, head/tail pointers log2(DEPTH) bits wrapping modulo DEPTH, occupancy count 0..DEPTH.
- Push: `wr_en && wr_ready` → store at tail, tail+1. `wr_ready` = (count != DEPTH), derived from registered count only. A pop in the same cycle does not make a full FIFO accept.
- Overflow: `wr_en && !wr_ready` → write dropped, `wr_ovf` set. Cleared only by reset.
- Port arbitration, combinational from `core_re` and registered state:
  - `core_re`=1: `ram_addr`=`core_addr`, `ram_we`=0; no pop.
  - `core_re`=0 and count>0: `ram_addr`/`ram_wdata`=head entry, `ram_we`=1; pop (head+1).
  - Otherwise `ram_we`=0, `ram_addr`=head addr, `ram_wdata`=head data (don't-care).
- Simultaneous push and pop: count unchanged; both pointers advance.
- Forwarding: on `core_re`, compare `core_addr` against all valid entries (registered state only; a write pushed in the same cycle is not visible). On multiple hits, the newest entry (closest to tail) wins. Register `fwd_hit`/`fwd_data`.
- `core_rdata` = `fwd_hit` ? `fwd_data` : `ram_rdata`, in the cycle after `core_re`. It is a combinational mux, but all of its selects and forward data are registered.
- Writes reach the RAM in acceptance order. No coalescing.

## Timing
- Reset (async assert, sync release): count=0, head=tail=0, `wr_ready`=1, `wr_ovf`=0, `ram_we`=0, `fwd_hit`=0, `fwd_data`=0. `core_rdata` then equals `ram_rdata`. FIFO contents are not cleared.
- Reset mid-operation discards pending entries. These writes are lost, by design.
- Write latency to RAM: at best, accepted in cycle t, `ram_we` in t+1. With continuous `core_re`, the write is deferred indefinitely.
- Read latency: 1 cycle, the same with or without a forward hit.
- Write visibility: a write accepted in cycle t is visible to a `core_re` issued in t+1 or later, either via forward or via RAM.
- Sustained throughput: one write per cycle while the core is idle. Full occurs after DEPTH consecutive accepted writes during core reads.

## Test plan
- Reset, then `wr_en` with addr 0x005, data 0xA5A5, core idle → `ram_we`=1, `ram_addr`=0x005, `ram_wdata`=0xA5A5 the next cycle; count returns to 0; `wr_ready` stays 1.
- Hold `core_re`=1 and push 4 writes (0x010..0x013) → `wr_ready`=0 after the 4th. A 5th `wr_en` sets `wr_ovf`=1 and is dropped. Release `core_re` → 4 RAM writes in order over 4 cycles; `wr_ready` returns to 1 after the first pop.
- Forwarding: with `core_re` held, push addr 0x020 data 0x1111, then addr 0x020 data 0x2222; read 0x020 → `core_rdata`=0x2222 one cycle later. RAM is still unwritten at that point.
- Same-cycle hazard: push 0x030/0xBEEF and `core_re` for 0x030 in the same cycle → `core_rdata` = old RAM value. Repeating the read the next cycle → 0xBEEF.
- Simultaneous push and pop with count=2, core idle, `wr_en`=1 → count stays 2, one RAM write issued. Run 1000 cycles of random push/read traffic, compare reads against a reference memory model, and check pointer wrap-around.
- Assert `RST` while count=3 → `ram_we`=0 and `wr_ready`=1 immediately (asynchronous). No pending writes reach the RAM after release.
